// File: rtl/fifo_stim_driver.sv
// fifo_stim_driver: LFSR-based stimulus source for a FIFO DUT.
// Sequences DUT reset, weighted random traffic and a drain phase, then flags completion.
module fifo_stim_driver #(
    parameter int          FIFO_WIDTH    = 16,
    parameter int          FIFO_DEPTH    = 8,
    parameter int          NUM_TXN       = 1000,
    parameter int          WR_EN_ON_DIST = 70,
    parameter int          RD_EN_ON_DIST = 30,
    parameter int          RST_PCT       = 2,
    parameter int          RST_CYCLES    = 2,
    parameter logic [31:0] LFSR_SEED     = 32'hACE1_2468
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  fifo_empty,
    output logic                  dut_rst_n,
    output logic [FIFO_WIDTH-1:0] data_in,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic                  sample_start,
    output logic                  test_finished,
    output logic [31:0]           txn_count
);

    typedef enum logic [2:0] {
        IDLE,
        DUT_RST,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [31:0] POLY      = 32'h8020_0003;
    localparam logic [31:0] NUM_TXN_W = 32'(NUM_TXN);
    localparam logic [31:0] RST_LAST  = 32'(RST_CYCLES - 1);
    localparam logic [31:0] DEPTH_W   = 32'(FIFO_DEPTH);
    localparam logic [7:0]  WR_TH     = 8'(WR_EN_ON_DIST);
    localparam logic [7:0]  RD_TH     = 8'(RD_EN_ON_DIST);
    localparam logic [7:0]  RST_TH    = 8'(RST_PCT);

    state_t                state_q;
    logic [31:0]           lfsr_q;
    logic [31:0]           lfsr_d;
    logic [31:0]           cnt_q;
    logic [31:0]           txn_q;
    logic                  rst_n_q;
    logic                  wr_q;
    logic                  rd_q;
    logic                  ss_q;
    logic                  fin_q;
    logic [FIFO_WIDTH-1:0] data_q;
    logic                  wr_hit;
    logic                  rd_hit;
    logic                  rst_hit;

    // Maps a 7-bit field onto 0..99 so thresholds read as percentages.
    function automatic logic [6:0] pct(input logic [6:0] f);
        return 7'((14'(f) * 14'd100) >> 7);
    endfunction

    always_comb begin
        lfsr_d  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'd0);
        wr_hit  = {1'b0, pct(lfsr_q[6:0])} < WR_TH;
        rd_hit  = {1'b0, pct(lfsr_q[13:7])} < RD_TH;
        rst_hit = {1'b0, pct(lfsr_q[20:14])} < RST_TH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
            txn_q   <= '0;
            rst_n_q <= 1'b1;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            ss_q    <= 1'b0;
            fin_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    rst_n_q <= 1'b1;
                    wr_q    <= 1'b0;
                    rd_q    <= 1'b0;
                    if (start) begin
                        // The start edge itself is the first reset cycle.
                        rst_n_q <= 1'b0;
                        cnt_q   <= 32'd1;
                        state_q <= (RST_CYCLES == 1) ? RUN : DUT_RST;
                    end
                end
                DUT_RST: begin
                    rst_n_q <= 1'b0;
                    wr_q    <= 1'b0;
                    rd_q    <= 1'b0;
                    if (cnt_q >= RST_LAST) begin
                        state_q <= RUN;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                RUN: begin
                    rst_n_q <= ~rst_hit;
                    wr_q    <= wr_hit;
                    rd_q    <= rd_hit;
                    data_q  <= lfsr_q[FIFO_WIDTH-1:0];
                    lfsr_q  <= lfsr_d;
                    ss_q    <= ~ss_q;
                    txn_q   <= txn_q + 32'd1;
                    if (txn_q + 32'd1 >= NUM_TXN_W) begin
                        state_q <= DRAIN;
                        cnt_q   <= '0;
                    end
                end
                DRAIN: begin
                    rst_n_q <= 1'b1;
                    wr_q    <= 1'b0;
                    rd_q    <= 1'b1;
                    ss_q    <= ~ss_q;
                    if (fifo_empty || cnt_q >= DEPTH_W) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                DONE: begin
                    rst_n_q <= 1'b1;
                    wr_q    <= 1'b0;
                    rd_q    <= 1'b0;
                    fin_q   <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dut_rst_n     = rst_n_q;
    assign data_in       = data_q;
    assign wr_en         = wr_q;
    assign rd_en         = rd_q;
    assign sample_start  = ss_q;
    assign test_finished = fin_q;
    assign txn_count     = txn_q;

endmodule
